wash_timer_bank: RTL and testbench

Multi-channel programmable interval timer for the washing-machine controller. It replaces single-purpose countdown timers with one bank of `N_CH` independent channels: fill, wash, rinse, spin and door-lock delays. Each channel supports one-shot or periodic mode, pause/resume, abort and live readback of the remaining count. All channels share one prescaler, so durations can be expressed in slow ticks rather than raw clocks.

---
 rtl/wash_timer_bank.sv | 156 +++++++++++++++
 tb/tb_wash_timer_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_timer_bank.sv
// wash_timer_bank
// Bank of N_CH independent programmable interval timers (fill, wash, rinse,
// spin, door-lock delays) driven by one shared prescaler tick.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      [N_CH]        per-channel load-and-run strobe (one clock)
//   abort      [N_CH]        per-channel stop; channel goes idle without done
//   pause      [N_CH]        per-channel level hold; count frozen while high
//   periodic   [N_CH]        per-channel mode, captured at start (1 = reload)
//   duration   [N_CH*WIDTH]  per-channel load value, channel i at [i*WIDTH +: WIDTH]
//   done       [N_CH]        registered one-clock expiry pulse
//   busy       [N_CH]        channel in RUN or HOLD
//   paused     [N_CH]        channel in HOLD
//   remaining  [N_CH*WIDTH]  registered live count, same packing as duration
module wash_timer_bank #(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         abort,
    input  logic [N_CH-1:0]         pause,
    input  logic [N_CH-1:0]         periodic,
    input  logic [N_CH*WIDTH-1:0]   duration,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         paused,
    output logic [N_CH*WIDTH-1:0]   remaining
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } ch_state_t;

    // ------------------------------------------------------------------
    // Shared prescaler: free-running 0..PRESCALE-1, never restarted by
    // channel activity. With PRESCALE=1 the counter sits at 0 and tick is
    // permanently high.
    // ------------------------------------------------------------------
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PRE_LAST);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    ch_state_t        state_q [N_CH];
    ch_state_t        state_d [N_CH];
    logic [WIDTH-1:0] count_q [N_CH];
    logic [WIDTH-1:0] count_d [N_CH];
    logic [N_CH-1:0]  mode_q;
    logic [N_CH-1:0]  mode_d;
    logic [N_CH-1:0]  done_q;
    logic [N_CH-1:0]  done_d;

    // Next-state logic. Priority per channel: abort > start > pause/tick.
    // A channel leaving HOLD with pause low processes the tick in that same
    // clock, so each HOLD clock costs exactly one tick of delay.
    always_comb begin
        logic [WIDTH-1:0] dur;
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: every signal driven here gets a default before any
            // branch, so no path leaves it unassigned and no latch is inferred.
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            mode_d[i]  = mode_q[i];
            done_d[i]  = 1'b0;
            dur        = duration[i*WIDTH +: WIDTH];

            if (abort[i]) begin
                state_d[i] = ST_IDLE;
                count_d[i] = '0;
            end else if (start[i]) begin
                // Restart discards the old count; an expiry in this same
                // clock is dropped because done_d stays low.
                count_d[i] = dur;
                mode_d[i]  = periodic[i];
                state_d[i] = pause[i] ? ST_HOLD : ST_RUN;
            end else if (state_q[i] != ST_IDLE) begin
                if (pause[i]) begin
                    state_d[i] = ST_HOLD;
                end else begin
                    state_d[i] = ST_RUN;
                    if (tick) begin
                        if (count_q[i] == '0) begin
                            // Expiry: zero triggers done rather than a
                            // decrement, so the count never wraps.
                            done_d[i] = 1'b1;
                            if (mode_q[i]) begin
                                count_d[i] = dur;
                            end else begin
                                state_d[i] = ST_IDLE;
                            end
                        end else begin
                            count_d[i] = count_q[i] - 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the per-channel arrays are small flop banks, not RAM, so
            // they are cleared by reset like any other register.
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
                count_q[i] <= '0;
            end
            mode_q <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
            mode_q <= mode_d;
            done_q <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign done = done_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign busy[g]                      = (state_q[g] != ST_IDLE);
        assign paused[g]                    = (state_q[g] == ST_HOLD);
        assign remaining[g*WIDTH +: WIDTH]  = count_q[g];
    end

endmodule

// File: tb/tb_wash_timer_bank.sv
// tb_wash_timer_bank
// Self-checking bench for wash_timer_bank. One 4-channel instance with
// PRESCALE=1 carries the directed tests; a scoreboard of expected done
// cycles per channel is filled by the stimulus and drained by a monitor.
// A second 1-channel instance with PRESCALE=4 covers prescaled timing.
module tb_wash_timer_bank;

    localparam int N  = 4;
    localparam int W  = 16;

    logic           clk;
    logic           reset;
    logic [N-1:0]   start, abort, pause, periodic;
    logic [N*W-1:0] duration;
    logic [N-1:0]   done, busy, paused;
    logic [N*W-1:0] remaining;

    logic [0:0]     b_start, b_abort, b_pause, b_periodic;
    logic [7:0]     b_duration;
    logic [0:0]     b_done, b_busy, b_paused;
    logic [7:0]     b_remaining;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int exp_q [N][$];
    int obs_b [$];

    wash_timer_bank #(.N_CH(N), .WIDTH(W), .PRESCALE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .pause     (pause),
        .periodic  (periodic),
        .duration  (duration),
        .done      (done),
        .busy      (busy),
        .paused    (paused),
        .remaining (remaining)
    );

    wash_timer_bank #(.N_CH(1), .WIDTH(8), .PRESCALE(4)) dut_p4 (
        .clk       (clk),
        .reset     (reset),
        .start     (b_start),
        .abort     (b_abort),
        .pause     (b_pause),
        .periodic  (b_periodic),
        .duration  (b_duration),
        .done      (b_done),
        .busy      (b_busy),
        .paused    (b_paused),
        .remaining (b_remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges so far; sampled only on falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint rem(input int c);
        return longint'(remaining[c*W +: W]);
    endfunction

    // Drive start/abort masks for exactly one rising edge; returns the index
    // of the edge that sampled them. Called right after a falling edge.
    task automatic strobe(input logic [N-1:0] s, input logic [N-1:0] a, output int k);
        start = s;
        abort = a;
        @(negedge clk);
        start = '0;
        abort = '0;
        k = cyc;
    endtask

    // Scoreboard monitor: every done pulse must match the head of its
    // channel's expected-cycle queue.
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (done[c]) begin
                if (exp_q[c].size() == 0) begin
                    check($sformatf("done_unexpected_ch%0d", c), cyc, -1);
                end else begin
                    int e;
                    e = exp_q[c].pop_front();
                    check($sformatf("done_cycle_ch%0d", c), cyc, e);
                end
            end
        end
        if (b_done[0]) obs_b.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, kb;

        reset = 1'b1;
        start = '0; abort = '0; pause = '0; periodic = '0; duration = '0;
        b_start = '0; b_abort = '0; b_pause = '0; b_periodic = '0; b_duration = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_done",   done,      0);
        check("rst_busy",   busy,      0);
        check("rst_paused", paused,    0);
        check("rst_remain", remaining, 0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- reset mid-run ----------------
        duration[0*W +: W] = 16'd10;
        strobe(4'b0001, 4'b0000, k);
        repeat (4) @(negedge clk);
        check("midrun_remain_before_reset", rem(0), 6);
        #2 reset = 1'b1;
        #1;
        check("midrun_rst_done",   done,      0);
        check("midrun_rst_busy",   busy,      0);
        check("midrun_rst_remain", remaining, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (14) @(negedge clk);
        check("midrun_busy_after_release", busy[0], 0);

        // ---------------- one-shot latency / readback ----------------
        duration[1*W +: W] = 16'd5;
        strobe(4'b0010, 4'b0000, k);
        exp_q[1].push_back(k + 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("oneshot_remain_%0d", i), rem(1), 5 - i);
            check($sformatf("oneshot_busy_%0d", i), busy[1], 1);
            @(negedge clk);
        end
        check("oneshot_busy_drop", busy[1], 0);
        check("oneshot_done_high", done[1], 1);
        repeat (3) @(negedge clk);

        // ---------------- periodic D=3 and D=0 together ----------------
        periodic[3:2]      = 2'b11;
        duration[2*W +: W] = 16'd3;
        duration[3*W +: W] = 16'd0;
        strobe(4'b1100, 4'b0000, k);
        for (int j = 1; j <= 5;  j++) exp_q[2].push_back(k + 4 * j);
        for (int j = 1; j <= 20; j++) exp_q[3].push_back(k + j);
        repeat (20) @(negedge clk);
        strobe(4'b0000, 4'b1100, k2);
        check("periodic_abort_busy",    busy[3:2], 0);
        check("periodic_abort_remain2", rem(2),    0);
        periodic = '0;
        repeat (3) @(negedge clk);

        // ---------------- pause ----------------
        duration[0*W +: W] = 16'd8;
        strobe(4'b0001, 4'b0000, k);
        exp_q[0].push_back(k + 12);
        @(negedge clk);
        check("pause_remain_pre", rem(0), 7);
        pause[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("pause_paused_%0d", i), paused[0], 1);
            check($sformatf("pause_remain_%0d", i), rem(0), 7);
        end
        pause[0] = 1'b0;
        @(negedge clk);
        check("pause_released", paused[0], 0);
        check("pause_resume_remain", rem(0), 6);
        repeat (9) @(negedge clk);

        // ---------------- abort after restart ----------------
        strobe(4'b0001, 4'b0000, k);
        repeat (3) @(negedge clk);
        strobe(4'b0000, 4'b0001, k2);
        check("abort_busy",   busy[0], 0);
        check("abort_remain", rem(0),  0);
        repeat (12) @(negedge clk);

        // ---------------- same-clock abort + start ----------------
        duration[1*W +: W] = 16'd20;
        strobe(4'b0010, 4'b0000, k);
        repeat (2) @(negedge clk);
        strobe(4'b0010, 4'b0010, k2);
        check("abort_start_busy",   busy[1], 0);
        check("abort_start_remain", rem(1),  0);

        // ---------------- start in the expiry clock ----------------
        duration[1*W +: W] = 16'd3;
        strobe(4'b0010, 4'b0000, k);
        repeat (3) @(negedge clk);
        check("expiry_restart_pre_remain", rem(1), 0);
        duration[1*W +: W] = 16'd6;
        strobe(4'b0010, 4'b0000, k2);
        check("expiry_restart_edge", k2, k + 4);
        check("expiry_restart_done", done[1], 0);
        check("expiry_restart_remain", rem(1), 6);
        check("expiry_restart_busy", busy[1], 1);
        exp_q[1].push_back(k2 + 7);
        repeat (9) @(negedge clk);

        // ---------------- prescaler P=4, D=2 periodic ----------------
        b_periodic = 1'b1;
        b_duration = 8'd2;
        b_start    = 1'b1;
        @(negedge clk);
        b_start    = 1'b0;
        kb = cyc;
        check("p4_busy_after_start",   b_busy,      1);
        check("p4_remain_after_start", b_remaining, 2);
        repeat (50) @(negedge clk);
        check("p4_done_count", obs_b.size(), 4);
        if (obs_b.size() >= 1) begin
            check("p4_first_latency_in_9_12",
                  ((obs_b[0] - kb) >= 9 && (obs_b[0] - kb) <= 12) ? 1 : 0, 1);
        end
        for (int i = 1; i < obs_b.size() && i < 4; i++) begin
            check($sformatf("p4_spacing_%0d", i), obs_b[i] - obs_b[i-1], 12);
        end
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        check("p4_abort_busy", b_busy, 0);

        // ---------------- scoreboard drained ----------------
        repeat (2) @(negedge clk);
        for (int c = 0; c < N; c++) begin
            check($sformatf("scoreboard_empty_ch%0d", c), exp_q[c].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
